doc_uart_sender: RTL and testbench



---
 rtl/doc_uart_sender_if.sv | 30 +++
 rtl/doc_uart_sender.sv | 198 +++++++++++++++++++
 tb/tb_doc_uart_sender.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doc_uart_sender_if.sv
// Document read port plus start/done/busy handshake between the text editor
// side and the UART document sender.
interface doc_uart_sender_if;
    logic       start;        // one-cycle request to send the document
    logic [7:0] read_data;    // document byte at read_addr (async read)
    logic       read_enable;  // sender owns the document read address
    logic [8:0] read_addr;    // {row[3:0], col[4:0]}
    logic       done;         // one-cycle pulse after the last frame
    logic       busy;         // transfer in progress

    // The sender drives the read address and status.
    modport master (
        input  start,
        input  read_data,
        output read_enable,
        output read_addr,
        output done,
        output busy
    );

    // The document owner / requester side.
    modport slave (
        output start,
        output read_data,
        input  read_enable,
        input  read_addr,
        input  done,
        input  busy
    );
endinterface

// File: rtl/doc_uart_sender.sv
// doc_uart_sender: walks the ROWS x COLS character document through the text
// editor read port and transmits it as 8N1 UART frames (LSB first), one byte
// per cell, with CR LF appended after every row. A done pulse (clear_data)
// follows a complete transfer when CLEAR_AFTER is set.
module doc_uart_sender #(
    parameter int BAUD_DIV    = 10416,  // clk cycles per UART bit
    parameter int ROWS        = 15,     // document rows sent
    parameter int COLS        = 20,     // document columns sent per row
    parameter bit CLEAR_AFTER = 1'b1    // pulse done after a full transfer
) (
    input  logic              clk,
    input  logic              rst,
    doc_uart_sender_if.master bus,
    output logic              tx
);

    localparam int                BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [4:0]        COL_CR    = 5'(COLS);
    localparam logic [4:0]        COL_LF    = 5'(COLS + 1);
    localparam logic [3:0]        ROW_LAST  = 4'(ROWS - 1);
    localparam logic [7:0]        CHAR_CR   = 8'h0D;
    localparam logic [7:0]        CHAR_LF   = 8'h0A;
    localparam logic [7:0]        CHAR_SP   = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [BAUD_W-1:0] baud_q;      // cycle within the current bit
    logic [2:0]        bit_q;       // data bit index, wraps 7 -> 0
    logic [3:0]        row_q;       // document row being sent
    logic [4:0]        col_q;       // column; COLS and COLS+1 select CR and LF
    logic [7:0]        shift_q;     // frame data, LSB goes out first
    logic [8:0]        addr_q;      // read address, held between fetches
    logic              ren_q;       // read port ownership

    logic              bit_end;     // last cycle of the current UART bit
    logic              last_col;    // LF of the current row is being sent
    logic              last_row;    // current row is the final one
    logic [7:0]        fetch_byte;  // byte to load during FETCH

    assign bit_end  = (baud_q == BAUD_LAST);
    assign last_col = (col_q == COL_LF);
    assign last_row = (row_q == ROW_LAST);

    // Select the byte for the current cell: mapped document data or CR/LF.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        fetch_byte = CHAR_LF;
        if (col_q < COL_CR) begin
            if (bus.read_data == 8'h00) begin
                fetch_byte = CHAR_SP;
            end else begin
                fetch_byte = {1'b0, bus.read_data[6:0]};
            end
        end else if (col_q == COL_CR) begin
            fetch_byte = CHAR_CR;
        end
    end

    // State register; reset wins over a coincident start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one fetch cycle, then start, 8 data bits and stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_col || !last_row) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: baud/bit timing, row/column walk, shift register, read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q  <= '0;
            bit_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        row_q  <= '0;
                        col_q  <= '0;
                        addr_q <= '0;
                        ren_q  <= 1'b1;
                        baud_q <= '0;
                        bit_q  <= '0;
                    end
                end
                FETCH: begin
                    shift_q <= fetch_byte;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
                START: begin
                    baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
                end
                DATA: begin
                    baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                    end
                end
                STOP: begin
                    baud_q <= bit_end ? '0 : baud_q + BAUD_W'(1);
                    if (bit_end) begin
                        if (!last_col) begin
                            col_q  <= col_q + 5'd1;
                            addr_q <= {row_q, col_q + 5'd1};
                        end else begin
                            col_q <= '0;
                            row_q <= row_q + 4'd1;
                            if (!last_row) begin
                                addr_q <= {row_q + 4'd1, 5'd0};
                            end else begin
                                // Release the read port as DONE is entered.
                                ren_q <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    ren_q <= 1'b0;
                end
                default: begin
                    ren_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decoded from the current state and datapath registers.
    always_comb begin
        tx              = 1'b1;
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == DONE) && CLEAR_AFTER;
        bus.read_enable = ren_q;
        bus.read_addr   = addr_q;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_doc_uart_sender.sv
// Directed bench for doc_uart_sender with BAUD_DIV=4, ROWS=2, COLS=3.
// A UART decoder watches the CLEAR_AFTER=1 instance; a second instance built
// with CLEAR_AFTER=0 covers the no-clear variant.
module tb_doc_uart_sender;

    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx1;
    logic tx0;
    int   cyc = 0;

    int total = 0;
    int bad   = 0;

    doc_uart_sender_if bus1();
    doc_uart_sender_if bus0();

    logic [7:0] doc_mem [0:511];
    assign bus1.read_data = doc_mem[bus1.read_addr];
    assign bus0.read_data = doc_mem[bus0.read_addr];

    doc_uart_sender #(.BAUD_DIV(BD), .ROWS(2), .COLS(3), .CLEAR_AFTER(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master),
        .tx  (tx1)
    );

    doc_uart_sender #(.BAUD_DIV(BD), .ROWS(2), .COLS(3), .CLEAR_AFTER(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master),
        .tx  (tx0)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Expected stream: row0 "ABC" CR LF, row1 0x00->space, 'z', 0xC1->'A', CR LF.
    logic [7:0] exp_bytes [10] = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A,
                                   8'h20, 8'h7A, 8'h41, 8'h0D, 8'h0A};
    logic [8:0] exp_addr  [10] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004,
                                   9'h020, 9'h021, 9'h022, 9'h023, 9'h024};

    // Monitor state for the CLEAR_AFTER=1 instance.
    logic [7:0] rx_q [$];
    int         fall_q [$];
    logic [8:0] addr_log [$];
    bit         dec_active = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_byte;
    int         stop_bad = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       busy_at_done = 1'b0;
    int         busy_cnt = 0;
    bit         addr_seen = 1'b0;
    logic [8:0] addr_prev = '0;
    int         done0_cnt = 0;
    int         busy0_cnt = 0;
    int         start_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (tx1 === 1'b0) begin
                    dec_active = 1'b1;
                    dec_t = 0;
                    fall_q.push_back(cyc);
                end
            end else begin
                dec_t++;
                if (dec_t >= BD + BD/2 && dec_t <= 8*BD + BD/2 && ((dec_t - BD - BD/2) % BD) == 0)
                    dec_byte[(dec_t - BD - BD/2) / BD] = tx1;
                if (dec_t == 9*BD + BD/2) begin
                    if (tx1 !== 1'b1) stop_bad++;
                    rx_q.push_back(dec_byte);
                end
                if (dec_t == 10*BD - 1) dec_active = 1'b0;
            end
            if (bus1.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = bus1.busy;
            end
            if (bus1.busy === 1'b1) busy_cnt++;
            if (bus1.read_enable === 1'b1 && (!addr_seen || bus1.read_addr !== addr_prev)) begin
                addr_log.push_back(bus1.read_addr);
                addr_prev = bus1.read_addr;
                addr_seen = 1'b1;
            end
            if (bus0.done === 1'b1) done0_cnt++;
            if (bus0.busy === 1'b1) busy0_cnt++;
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        fall_q.delete();
        addr_log.delete();
        addr_seen = 1'b0;
        stop_bad  = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        done0_cnt = 0;
        busy0_cnt = 0;
    endtask

    task automatic pulse_start1();
        @(negedge clk);
        bus1.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic wait_idle1(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus1.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_falls(input int n, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (fall_q.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx1); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
        total++; if (bus1.read_enable !== 1'b0) begin bad++; $display("FAIL reset_ren: got %b expected 0", bus1.read_enable); end
        total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus1.done); end
        total++; if (bus1.read_addr !== 9'h000) begin bad++; $display("FAIL reset_addr: got %h expected 000", bus1.read_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        clear_logs();
        pulse_start1();
        wait_idle1(to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout: busy still high after 700 cycles"); end
        total++; if (rx_q.size() != 10) begin bad++; $display("FAIL basic_count: got %0d bytes expected 10", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_bytes[i]) begin bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp_bytes[i]); end
        end
        total++; if (addr_log.size() != 10) begin bad++; $display("FAIL basic_addr_count: got %0d expected 10", addr_log.size()); end
        for (int i = 0; i < 10 && i < addr_log.size(); i++) begin
            total++;
            if (addr_log[i] !== exp_addr[i]) begin bad++; $display("FAIL basic_addr%0d: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
        total++; if (stop_bad != 0) begin bad++; $display("FAIL basic_stop_bits: got %0d low stop bits expected 0", stop_bad); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done: got %b expected 1", busy_at_done); end
        total++; if (done_cyc - start_cyc != 411) begin bad++; $display("FAIL basic_done_latency: got %0d expected 411", done_cyc - start_cyc); end
        total++; if (busy_cnt != 411) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 411", busy_cnt); end
        if (fall_q.size() > 0) begin
            total++;
            if (fall_q[0] - start_cyc != 2) begin bad++; $display("FAIL basic_first_fall: got %0d expected 2", fall_q[0] - start_cyc); end
        end
        for (int i = 1; i < fall_q.size(); i++) begin
            total++;
            if (fall_q[i] - fall_q[i-1] != 10*BD + 1) begin bad++; $display("FAIL basic_frame_spacing%0d: got %0d expected %0d", i, fall_q[i] - fall_q[i-1], 10*BD + 1); end
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        clear_logs();
        pulse_start1();
        wait_falls(3, to);
        total++; if (to) begin bad++; $display("FAIL ignore_wait_frame3: third frame never started"); end
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_idle1(to);
        total++; if (to) begin bad++; $display("FAIL ignore_timeout: busy still high after 700 cycles"); end
        repeat (60) @(negedge clk);
        total++; if (rx_q.size() != 10) begin bad++; $display("FAIL ignore_count: got %0d bytes expected 10", rx_q.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL ignore_not_queued: busy got %b expected 0", bus1.busy); end
        if (rx_q.size() > 9) begin
            total++;
            if (rx_q[9] !== 8'h0A) begin bad++; $display("FAIL ignore_last_byte: got %h expected 0a", rx_q[9]); end
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        clear_logs();
        pulse_start1();
        wait_falls(2, to);
        total++; if (to) begin bad++; $display("FAIL midrst_wait_frame2: second frame never started"); end
        repeat (2*BD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (tx1 !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b expected 1", tx1); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", bus1.busy); end
        total++; if (bus1.read_enable !== 1'b0) begin bad++; $display("FAIL midrst_ren: got %b expected 0", bus1.read_enable); end
        total++; if (bus1.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b expected 0", bus1.done); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (done_cnt != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL midrst_stays_idle: busy got %b expected 0", bus1.busy); end
        clear_logs();
        pulse_start1();
        wait_idle1(to);
        total++; if (to) begin bad++; $display("FAIL midrst_resend_timeout: busy still high after 700 cycles"); end
        total++; if (rx_q.size() != 10) begin bad++; $display("FAIL midrst_resend_count: got %0d bytes expected 10", rx_q.size()); end
        if (rx_q.size() > 0) begin
            total++;
            if (rx_q[0] !== 8'h41) begin bad++; $display("FAIL midrst_resend_first: got %h expected 41", rx_q[0]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL midrst_resend_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_clear_after0();
        bit to;
        clear_logs();
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (bus0.busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL noclear_timeout: busy still high after 700 cycles"); end
        total++; if (done0_cnt != 0) begin bad++; $display("FAIL noclear_done: got %0d pulses expected 0", done0_cnt); end
        total++; if (busy0_cnt != 411) begin bad++; $display("FAIL noclear_busy_cycles: got %0d expected 411", busy0_cnt); end
        total++; if (tx0 !== 1'b1) begin bad++; $display("FAIL noclear_tx_idle: got %b expected 1", tx0); end
    endtask

    initial begin
        bus1.start = 1'b0;
        bus0.start = 1'b0;
        for (int i = 0; i < 512; i++) doc_mem[i] = 8'hEE;
        doc_mem[9'h000] = 8'h41;
        doc_mem[9'h001] = 8'h42;
        doc_mem[9'h002] = 8'h43;
        doc_mem[9'h020] = 8'h00;
        doc_mem[9'h021] = 8'h7A;
        doc_mem[9'h022] = 8'hC1;

        test_reset();
        test_basic();
        test_start_ignored();
        test_mid_reset();
        test_clear_after0();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
